// File: rtl/mipi_tx_timing_ctrl.sv
// TX timing regenerator between the 4-to-6 line buffer and the MIPI TX controller.
// Rebuilds VSYNC from the RX frame start, enforces a VSYNC-to-HSYNC guard, gates lines and checks geometry.
module mipi_tx_timing_ctrl #(
  parameter int MIPI_TX_HRES = 1920,
  parameter int MIPI_TX_VRES = 1080,
  parameter int PIX_PER_BEAT = 6,
  parameter int DATA_WIDTH   = 60,
  parameter int VS_WIDTH     = 16,
  parameter int VS_TO_HS     = 64
) (
  input  logic                  mipi_pclk,
  input  logic                  i_rst,
  input  logic                  i_rx_vsync,
  input  logic                  i_line_hsync,
  input  logic                  i_line_valid,
  input  logic [DATA_WIDTH-1:0] i_line_data,
  input  logic                  i_clear,
  output logic                  mipi_tx_vsync,
  output logic                  mipi_tx_hsync,
  output logic                  mipi_tx_valid,
  output logic [DATA_WIDTH-1:0] mipi_tx_data,
  output logic [15:0]           o_frame_cnt,
  output logic [11:0]           o_line_cnt,
  output logic [15:0]           o_drop_cnt,
  output logic                  o_err_hres,
  output logic                  o_err_vres
);

  localparam int EXP_BEATS = MIPI_TX_HRES / PIX_PER_BEAT;
  localparam logic [10:0] EXP_BEATS_W = 11'(EXP_BEATS);
  localparam logic [11:0] VRES_W      = 12'(MIPI_TX_VRES);
  localparam int TMAX = (VS_WIDTH > VS_TO_HS) ? VS_WIDTH : VS_TO_HS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] VS_LAST    = TW'(VS_WIDTH - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(VS_TO_HS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VSYNC  = 2'd1,
    GUARD  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                  vs_s1, vs_s1_d;
  logic                  hs_s1, hs_s1_d;
  logic                  valid_s1;
  logic [DATA_WIDTH-1:0] data_s1;

  logic [TW-1:0] timer;
  logic          pend_q;
  logic          pass_q;
  logic [10:0]   beats;
  logic [11:0]   cur_lines;

  logic        vs_rise, line_start, line_end;
  logic        pass_ok, pass_now, in_prog, pass_end;
  logic        set_pend, enter_vs, close_frame;
  logic        fwd_beat;
  logic [11:0] lines_inc;
  logic        hres_evt, vres_evt, drop_evt;

  assign vs_rise    = vs_s1 & ~vs_s1_d;
  assign line_start = hs_s1 & ~hs_s1_d;
  assign line_end   = ~hs_s1 & hs_s1_d;

  // The pass/drop verdict is taken once at line_start and held in pass_q for the rest of the line.
  assign pass_ok  = (state == ACTIVE) && !pend_q;
  assign pass_now = line_start ? pass_ok : pass_q;
  assign in_prog  = hs_s1 & pass_now;
  assign pass_end = line_end & pass_q;
  assign fwd_beat = hs_s1 & valid_s1 & pass_now;

  assign lines_inc = (pass_end && (cur_lines != 12'hFFF)) ? cur_lines + 12'd1 : cur_lines;
  assign hres_evt  = pass_end && (beats != EXP_BEATS_W);
  assign vres_evt  = close_frame && (lines_inc != VRES_W);
  assign drop_evt  = line_start & ~pass_ok;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt   = state;
    set_pend    = 1'b0;
    enter_vs    = 1'b0;
    close_frame = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_nxt = VSYNC;
          enter_vs  = 1'b1;
        end
      end
      VSYNC: begin
        if (timer == VS_LAST) state_nxt = GUARD;
      end
      GUARD: begin
        if (timer == GUARD_LAST) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        // A frame start during a passed line waits for that line's end before restarting.
        if (pend_q ? line_end : (vs_rise && !in_prog)) begin
          state_nxt   = VSYNC;
          enter_vs    = 1'b1;
          close_frame = 1'b1;
        end else if (vs_rise && in_prog && !pend_q) begin
          set_pend = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mipi_pclk) begin
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      vs_s1    <= 1'b0;
      vs_s1_d  <= 1'b0;
      hs_s1    <= 1'b0;
      hs_s1_d  <= 1'b0;
      valid_s1 <= 1'b0;
      data_s1  <= '0;
    end else begin
      vs_s1    <= i_rx_vsync;
      vs_s1_d  <= vs_s1;
      hs_s1    <= i_line_hsync;
      hs_s1_d  <= hs_s1;
      valid_s1 <= i_line_valid;
      data_s1  <= i_line_data;
    end
  end

  always_ff @(posedge mipi_pclk) begin
    if (i_rst) begin
      state     <= IDLE;
      timer     <= '0;
      pend_q    <= 1'b0;
      pass_q    <= 1'b0;
      beats     <= '0;
      cur_lines <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == state) && ((state == VSYNC) || (state == GUARD))) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end
      pend_q    <= enter_vs ? 1'b0 : (pend_q | set_pend);
      pass_q    <= pass_now & hs_s1;
      cur_lines <= close_frame ? 12'd0 : lines_inc;
      if (line_start) begin
        beats <= {10'd0, valid_s1};
      end else if (fwd_beat && (beats != 11'h7FF)) begin
        beats <= beats + 11'd1;
      end
    end
  end

  // TX outputs and status; VSYNC out trails the VSYNC state by one cycle to line up with the data path.
  always_ff @(posedge mipi_pclk) begin
    if (i_rst) begin
      mipi_tx_vsync <= 1'b0;
      mipi_tx_hsync <= 1'b0;
      mipi_tx_valid <= 1'b0;
      mipi_tx_data  <= '0;
      o_frame_cnt   <= '0;
      o_line_cnt    <= '0;
      o_drop_cnt    <= '0;
      o_err_hres    <= 1'b0;
      o_err_vres    <= 1'b0;
    end else begin
      mipi_tx_vsync <= (state == VSYNC);
      mipi_tx_hsync <= hs_s1 & pass_now;
      mipi_tx_valid <= fwd_beat;
      mipi_tx_data  <= fwd_beat ? data_s1 : '0;
      if (enter_vs)    o_frame_cnt <= o_frame_cnt + 16'd1;
      if (close_frame) o_line_cnt  <= lines_inc;
      o_err_hres <= hres_evt | (o_err_hres & ~i_clear);
      o_err_vres <= vres_evt | (o_err_vres & ~i_clear);
      if (drop_evt) begin
        if (i_clear)                     o_drop_cnt <= 16'd1;
        else if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      end else if (i_clear) begin
        o_drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mipi_tx_timing_ctrl.sv
// Directed bench for mipi_tx_timing_ctrl on a reduced 48x4 geometry (8 beats per line, 4 lines per frame).
// Expected values are hand-derived from the cycle timing of VSYNC, guard window, and 2-cycle data path.
module tb_mipi_tx_timing_ctrl;

  localparam int DW   = 60;
  localparam int HRES = 48;
  localparam int VRES = 4;
  localparam int PPB  = 6;
  localparam int VSW  = 16;
  localparam int VTH  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_vsync, line_hsync, line_valid, clear;
  logic [DW-1:0] line_data;
  logic          tx_vsync, tx_hsync, tx_valid;
  logic [DW-1:0] tx_data;
  logic [15:0]   frame_cnt, drop_cnt;
  logic [11:0]   line_cnt;
  logic          err_hres, err_vres;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mipi_tx_timing_ctrl #(
    .MIPI_TX_HRES(HRES), .MIPI_TX_VRES(VRES), .PIX_PER_BEAT(PPB),
    .DATA_WIDTH(DW), .VS_WIDTH(VSW), .VS_TO_HS(VTH)
  ) dut (
    .mipi_pclk    (clk),
    .i_rst        (rst),
    .i_rx_vsync   (rx_vsync),
    .i_line_hsync (line_hsync),
    .i_line_valid (line_valid),
    .i_line_data  (line_data),
    .i_clear      (clear),
    .mipi_tx_vsync(tx_vsync),
    .mipi_tx_hsync(tx_hsync),
    .mipi_tx_valid(tx_valid),
    .mipi_tx_data (tx_data),
    .o_frame_cnt  (frame_cnt),
    .o_line_cnt   (line_cnt),
    .o_drop_cnt   (drop_cnt),
    .o_err_hres   (err_hres),
    .o_err_vres   (err_vres)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_vs();
    rx_vsync = 1'b1;
    step();
    rx_vsync = 1'b0;
    step();
  endtask

  // Drives one line of n beats plus two idle cycles; outputs are compared against inputs two cycles earlier.
  task automatic send_line(input int n, input bit pass, input int vs_at, input string tag);
    logic [DW-1:0] d [0:63];
    logic          h [0:63];
    logic          eh, ev;
    logic [DW-1:0] ed;
    for (int c = 0; c <= n + 1; c++) begin
      h[c] = (c < n);
      d[c] = DW'({$urandom(), $urandom()});
      line_hsync = h[c];
      line_valid = 1'b1;
      line_data  = d[c];
      if (c == vs_at)     rx_vsync = 1'b1;
      if (c == vs_at + 2) rx_vsync = 1'b0;
      step();
      if (c >= 1) begin
        eh = pass & h[c-1];
        ev = eh;
        ed = ev ? d[c-1] : '0;
        chk({tag, "_hsync"}, 64'(tx_hsync), 64'(eh));
        chk({tag, "_valid"}, 64'(tx_valid), 64'(ev));
        chk({tag, "_data"},  64'(tx_data),  64'(ed));
      end
    end
    line_valid = 1'b0;
    line_data  = '0;
  endtask

  initial begin
    int vs_high;
    rst = 1'b1; rx_vsync = 1'b0; line_hsync = 1'b0; line_valid = 1'b0;
    line_data = '0; clear = 1'b0;
    steps(3);
    chk("rst_vsync", 64'(tx_vsync),  64'd0);
    chk("rst_hsync", 64'(tx_hsync),  64'd0);
    chk("rst_data",  64'(tx_data),   64'd0);
    chk("rst_frame", 64'(frame_cnt), 64'd0);
    chk("rst_drop",  64'(drop_cnt),  64'd0);
    rst = 1'b0;
    step();

    // Frame start: VSYNC high for exactly VSW cycles, two cycles after the stage-1 edge.
    rx_vsync = 1'b1;
    step();
    chk("vs_pre0", 64'(tx_vsync), 64'd0);
    rx_vsync = 1'b0;
    step();
    chk("vs_pre1",  64'(tx_vsync),  64'd0);
    chk("frame1",   64'(frame_cnt), 64'd1);
    step();
    chk("vs_first", 64'(tx_vsync), 64'd1);
    vs_high = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_vsync) vs_high++;
    end
    chk("vs_width", 64'(vs_high), 64'(VSW));

    // Line inside the guard window is dropped.
    send_line(8, 1'b0, -1, "guard");
    chk("guard_drop",  64'(drop_cnt),  64'd1);
    chk("guard_frame", 64'(frame_cnt), 64'd1);
    steps(50);

    // Full frame of VRES correct lines, closed by the next frame start.
    for (int l = 0; l < VRES; l++) send_line(8, 1'b1, -1, "frame2");
    chk("hres_ok", 64'(err_hres), 64'd0);
    pulse_vs();
    chk("close_lines", 64'(line_cnt),  64'(VRES));
    chk("close_vres",  64'(err_vres),  64'd0);
    chk("frame2",      64'(frame_cnt), 64'd2);
    steps(80);

    // Short line raises the beat error; clear drops it together with the drop counter.
    send_line(7, 1'b1, -1, "short");
    chk("hres_set", 64'(err_hres), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("hres_clr", 64'(err_hres), 64'd0);
    chk("drop_clr", 64'(drop_cnt), 64'd0);

    // Frame start mid-line: the line completes, VSYNC follows its end.
    send_line(8, 1'b1, 3, "midvs");
    chk("midvs_hres",    64'(err_hres),  64'd0);
    chk("midvs_vs_hold", 64'(tx_vsync),  64'd0);
    chk("midvs_frame",   64'(frame_cnt), 64'd3);
    chk("midvs_lines",   64'(line_cnt),  64'd2);
    chk("midvs_vres",    64'(err_vres),  64'd1);
    step();
    chk("midvs_vs_rise", 64'(tx_vsync), 64'd1);
    pulse_vs();
    step();
    chk("vs_ignored", 64'(frame_cnt), 64'd3);
    steps(80);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("vres_clr", 64'(err_vres), 64'd0);

    // Frame one line short.
    for (int l = 0; l < VRES - 1; l++) send_line(8, 1'b1, -1, "short_frame");
    pulse_vs();
    chk("sf_lines", 64'(line_cnt),  64'(VRES - 1));
    chk("sf_vres",  64'(err_vres),  64'd1);
    chk("sf_frame", 64'(frame_cnt), 64'd4);
    steps(80);

    // Reset in the middle of a passed line.
    line_hsync = 1'b1;
    line_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      line_data = DW'({$urandom(), $urandom()});
      step();
    end
    chk("pre_rst_hsync", 64'(tx_hsync), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_vsync", 64'(tx_vsync),  64'd0);
    chk("mr_hsync", 64'(tx_hsync),  64'd0);
    chk("mr_valid", 64'(tx_valid),  64'd0);
    chk("mr_data",  64'(tx_data),   64'd0);
    chk("mr_frame", 64'(frame_cnt), 64'd0);
    chk("mr_lines", 64'(line_cnt),  64'd0);
    chk("mr_drop",  64'(drop_cnt),  64'd0);
    chk("mr_hres",  64'(err_hres),  64'd0);
    chk("mr_vres",  64'(err_vres),  64'd0);
    step();
    step();
    chk("post_rst_hsync", 64'(tx_hsync), 64'd0);
    chk("post_rst_drop",  64'(drop_cnt), 64'd1);
    line_hsync = 1'b0;
    line_valid = 1'b0;
    steps(2);
    send_line(8, 1'b0, -1, "idle_line");
    chk("idle_drop", 64'(drop_cnt), 64'd2);
    pulse_vs();
    chk("restart_frame", 64'(frame_cnt), 64'd1);
    steps(80);
    send_line(8, 1'b1, -1, "recover");
    chk("recover_drop", 64'(drop_cnt), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mipi_tx_timing_ctrl.md
Name: mipi_tx_timing_ctrl

Overview:
Sits directly downstream of the RX-to-TX line buffer (4-to-6 repack) and directly upstream of the MIPI TX controller inputs. It regenerates a clean TX VSYNC pulse from the RX frame-start edge and enforces a VSYNC-to-first-HSYNC guard. It drops lines that fall outside the active window and gates HSYNC/VALID/DATA toward TX. It also checks per-line beat count and per-frame line count against the programmed resolution. This replaces the free-running RAM-based VSYNC delay.

Parameters:
MIPI_TX_HRES, 1920, pixels per line
MIPI_TX_VRES, 1080, lines per frame
PIX_PER_BEAT, 6, pixels per input beat; expected beats per line EXP_BEATS = MIPI_TX_HRES/PIX_PER_BEAT (320)
DATA_WIDTH, 60, pixel data bus width
VS_WIDTH, 16, TX VSYNC high time in cycles (>=1)
VS_TO_HS, 64, guard cycles after VSYNC falls before a line may start (>=1)

Ports:
mipi_pclk  in  1  pixel clock; sole clock
i_rst  in  1  synchronous reset, active-high
i_rx_vsync  in  1  RX frame-valid level (VC0); rising edge = frame start
i_line_hsync  in  1  line buffer HSYNC level; high for the duration of a line
i_line_valid  in  1  data beat qualifier, meaningful only while i_line_hsync=1
i_line_data  in  DATA_WIDTH  beat data
i_clear  in  1  clears sticky error flags and drop counter
mipi_tx_vsync  out  1  regenerated TX VSYNC pulse
mipi_tx_hsync  out  1  gated HSYNC
mipi_tx_valid  out  1  gated VALID
mipi_tx_data  out  DATA_WIDTH  gated data; 0 when mipi_tx_valid=0
o_frame_cnt  out  16  frames started, wraps at 0xFFFF->0
o_line_cnt  out  12  lines passed in the last completed frame
o_drop_cnt  out  16  dropped lines, saturates at 0xFFFF
o_err_hres  out  1  sticky: a passed line had beats != EXP_BEATS
o_err_vres  out  1  sticky: a completed frame had lines != MIPI_TX_VRES

Behaviour:
- Reset (i_rst=1 at a clock edge): all outputs 0, state IDLE, internal counters 0, edge registers 0. Reset mid-line or mid-frame aborts immediately; TX outputs are 0 the following cycle.
- Edge detect: inputs registered once (stage 1). vs_rise = vs_s1 & ~vs_s1_d. line_start = hs_s1 & ~hs_s1_d. line_end = ~hs_s1 & hs_s1_d.
- Datapath latency: 2 cycles. The input at cycle t appears on the mipi_tx_* outputs at t+2 when the line is passed.
- FSM:
  - IDLE: wait for vs_rise, then go to VSYNC.
  - VSYNC: mipi_tx_vsync=1 for exactly VS_WIDTH cycles, then go to GUARD.
  - GUARD: count VS_TO_HS cycles, then go to ACTIVE.
  - ACTIVE: lines pass. On vs_rise, close the frame and go to VSYNC.
- VSYNC timing: a vs_rise detected at stage 1 on cycle t makes mipi_tx_vsync high from t+2 to t+1+VS_WIDTH.
- vs_rise in VSYNC or GUARD: ignored; no frame count, no restart.
- vs_rise in ACTIVE while a passed line is in progress: set a pending flag and let the line finish. Enter VSYNC on the cycle after line_end.
- vs_rise and line_end in the same cycle: treated as not in progress; go straight to VSYNC.
- Frame close happens on the ACTIVE->VSYNC transition:
  - o_line_cnt <= current line count.
  - o_err_vres set if the count != MIPI_TX_VRES.
  - Current line count cleared.
  - The IDLE->VSYNC transition does not close a frame.
- o_frame_cnt increments on every entry to VSYNC.
- Pass/drop decision is made once at line_start:
  - State ACTIVE and no pending vsync: pass the whole line.
  - Otherwise: drop the whole line, even if GUARD expires mid-line. o_drop_cnt increments at line_start.
- Passed line:
  - mipi_tx_hsync follows hs_s1 (delayed 1).
  - mipi_tx_valid = valid_s1 & hs_s1.
  - Beats are counted (11-bit, saturating).
  - At line_end the line counter increments (12-bit, saturating at 4095). o_err_hres is set if beats != EXP_BEATS.
- Dropped line: mipi_tx_hsync, mipi_tx_valid and mipi_tx_data stay 0.
- i_line_valid while i_line_hsync=0: ignored, never forwarded.
- i_clear: clears o_err_hres, o_err_vres and o_drop_cnt. If an error event occurs in the same cycle, the set wins.

Test Plan:
- Reset, then vs_rise at cycle 10 -> mipi_tx_vsync high cycles 12..27; first line starting before cycle 92 dropped (o_drop_cnt=1); o_frame_cnt=1.
- Full frame of 1080 lines × 320 beats, then a second vs_rise -> o_line_cnt=1080; o_err_vres=0; o_err_hres=0; TX data equals input delayed 2 cycles beat-for-beat.
- One line of 319 beats -> o_err_hres=1 at its line_end. Then i_clear -> o_err_hres=0 next cycle.
- vs_rise at beat 100 of a passed line -> line completes with 320 beats; mipi_tx_vsync rises 2 cycles after line_end stage-1 detection; o_frame_cnt increments once.
- Frame of 1079 lines -> o_line_cnt=1079 and o_err_vres=1. A second vs_rise during VSYNC leaves o_frame_cnt unchanged.
- i_rst asserted mid-line at beat 50 -> all outputs 0 next cycle; the next line is dropped until a new vs_rise plus VS_WIDTH+VS_TO_HS cycles elapse.
